// File: rtl/arp_rx.sv
// Receive-side ARP parser: validates single-beat ARP frames, latches requester SHA/SPA, learns peer from replies.
// arp_ack_tx rises one cycle after a matched request and drops one cycle after done; tready is 1 out of reset (never back-pressures).
module arp_rx #(
   parameter int C_AXIS_DATA_WIDTH = 512,
   parameter int CNT_WIDTH         = 16
) (
   input  logic                           clk,
   input  logic                           rstn,
   input  logic [C_AXIS_DATA_WIDTH-1:0]   rx_s_axis_tdata,
   input  logic [C_AXIS_DATA_WIDTH/8-1:0] rx_s_axis_tkeep,
   input  logic                           rx_s_axis_tvalid,
   input  logic                           rx_s_axis_tlast,
   output logic                           rx_s_axis_tready,
   input  logic [47:0]                    local_mac,
   input  logic [31:0]                    local_ip,
   output logic                           arp_ack_tx,
   input  logic                           arp_ack_tx_done,
   output logic [47:0]                    arp_src_mac,
   output logic [31:0]                    arp_src_ip,
   output logic [47:0]                    peer_mac,
   output logic [31:0]                    peer_ip,
   output logic                           peer_valid,
   output logic [CNT_WIDTH-1:0]           arp_req_cnt,
   output logic [CNT_WIDTH-1:0]           arp_drop_cnt
);
   typedef enum logic {S_IDLE, S_WAIT} state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   state_t      state, next_state;
   logic        sof;
   logic        beat;
   logic        hit, req_hit, rsp_hit;
   logic        accept, drop;
   logic [7:0]  b [42];
   logic [47:0] da, sha;
   logic [31:0] spa, tpa;
   logic [15:0] etype, htype, ptype, oper;
   logic [7:0]  hlen, plen;
   logic        unused_bits;

   assign unused_bits = ^{rx_s_axis_tdata[C_AXIS_DATA_WIDTH-1:336],
                          rx_s_axis_tkeep[C_AXIS_DATA_WIDTH/8-1:42]};

   always_comb begin
      for (int i = 0; i < 42; i++) b[i] = rx_s_axis_tdata[8*i +: 8];
   end

   // Wire order is big-endian: lowest byte index is the field MSB.
   assign da    = {b[0], b[1], b[2], b[3], b[4], b[5]};
   assign etype = {b[12], b[13]};
   assign htype = {b[14], b[15]};
   assign ptype = {b[16], b[17]};
   assign hlen  = b[18];
   assign plen  = b[19];
   assign oper  = {b[20], b[21]};
   assign sha   = {b[22], b[23], b[24], b[25], b[26], b[27]};
   assign spa   = {b[28], b[29], b[30], b[31]};
   assign tpa   = {b[38], b[39], b[40], b[41]};

   assign beat = rx_s_axis_tvalid & rx_s_axis_tready;
   assign hit  = beat & sof & (&rx_s_axis_tkeep[41:0]) &
                 (etype == 16'h0806) & (htype == 16'h0001) & (ptype == 16'h0800) &
                 (hlen == 8'd6) & (plen == 8'd4) &
                 ((da == local_mac) | (da == 48'hFFFF_FFFF_FFFF)) & (tpa == local_ip);
   assign req_hit = hit & (oper == 16'h0001);
   assign rsp_hit = hit & (oper == 16'h0002);

   assign arp_ack_tx = (state == S_WAIT);

   always_comb begin
      next_state = state;
      accept     = 1'b0;
      drop       = 1'b0;
      case (state)
         S_IDLE: begin
            if (req_hit) begin
               accept     = 1'b1;
               next_state = S_WAIT;
            end
         end
         S_WAIT: begin
            drop = req_hit;
            if (arp_ack_tx_done) next_state = S_IDLE;
         end
         default: next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state            <= S_IDLE;
         sof              <= 1'b1;
         rx_s_axis_tready <= 1'b0;
         arp_src_mac      <= '0;
         arp_src_ip       <= '0;
         peer_mac         <= '0;
         peer_ip          <= '0;
         peer_valid       <= 1'b0;
         arp_req_cnt      <= '0;
         arp_drop_cnt     <= '0;
      end else begin
         state            <= next_state;
         rx_s_axis_tready <= 1'b1;
         if (beat) sof <= rx_s_axis_tlast;
         if (accept) begin
            arp_src_mac <= sha;
            arp_src_ip  <= spa;
            if (arp_req_cnt != '1) arp_req_cnt <= arp_req_cnt + CNT_ONE;
         end
         if (drop && arp_drop_cnt != '1) arp_drop_cnt <= arp_drop_cnt + CNT_ONE;
         if (rsp_hit) begin
            peer_mac   <= sha;
            peer_ip    <= spa;
            peer_valid <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_arp_rx.sv
// Randomised bench for arp_rx with a field-level reference model of the ARP rules.
module tb_arp_rx;
   localparam int CW = 4;
   localparam int CMAX = (1 << CW) - 1;
   localparam logic [47:0] LMAC  = 48'h02_00_5E_10_20_07;
   localparam logic [31:0] LIP   = 32'hC0A8_0114;
   localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
   localparam logic [63:0] KALL  = 64'hFFFF_FFFF_FFFF_FFFF;

   typedef struct {
      logic [47:0] da;
      logic [15:0] et, ht, pt;
      logic [7:0]  hl, pl;
      logic [15:0] op;
      logic [47:0] sha;
      logic [31:0] spa;
      logic [47:0] tha;
      logic [31:0] tpa;
   } arp_f_t;

   logic          clk = 1'b0;
   logic          rstn;
   logic [511:0]  tdata;
   logic [63:0]   tkeep;
   logic          tvalid, tlast, tready;
   logic [47:0]   local_mac;
   logic [31:0]   local_ip;
   logic          ack, ack_done;
   logic [47:0]   src_mac, peer_mac;
   logic [31:0]   src_ip, peer_ip;
   logic          peer_valid;
   logic [CW-1:0] req_cnt, drop_cnt;

   always #5 clk = ~clk;

   arp_rx #(.C_AXIS_DATA_WIDTH(512), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rstn(rstn),
      .rx_s_axis_tdata(tdata), .rx_s_axis_tkeep(tkeep), .rx_s_axis_tvalid(tvalid),
      .rx_s_axis_tlast(tlast), .rx_s_axis_tready(tready),
      .local_mac(local_mac), .local_ip(local_ip),
      .arp_ack_tx(ack), .arp_ack_tx_done(ack_done),
      .arp_src_mac(src_mac), .arp_src_ip(src_ip),
      .peer_mac(peer_mac), .peer_ip(peer_ip), .peer_valid(peer_valid),
      .arp_req_cnt(req_cnt), .arp_drop_cnt(drop_cnt)
   );

   int n_vec = 0;
   int n_bad = 0;

   // reference model state
   logic        m_rdy, m_sof, m_pend, m_peer_vld;
   logic [47:0] m_src_mac, m_peer_mac;
   logic [31:0] m_src_ip, m_peer_ip;
   int          m_req, m_drop;

   task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [511:0] mk_frame(input arp_f_t f);
      logic [335:0] hdr;
      logic [511:0] d;
      hdr = {f.da, 48'h0A0B_0C0D_0E0F, f.et, f.ht, f.pt, f.hl, f.pl, f.op,
             f.sha, f.spa, f.tha, f.tpa};
      for (int i = 0; i < 64; i++) begin
         if (i < 42) d[8*i +: 8] = hdr[335 - 8*i -: 8];
         else        d[8*i +: 8] = 8'($urandom);
      end
      return d;
   endfunction

   function automatic arp_f_t mk_arp(input logic [47:0] da, input logic [15:0] op,
                                     input logic [47:0] sha, input logic [31:0] spa,
                                     input logic [31:0] tpa);
      arp_f_t f;
      f.da = da; f.et = 16'h0806; f.ht = 16'h0001; f.pt = 16'h0800;
      f.hl = 8'd6; f.pl = 8'd4; f.op = op; f.sha = sha; f.spa = spa;
      f.tha = 48'h0; f.tpa = tpa;
      return f;
   endfunction

   function automatic arp_f_t rand_frame();
      arp_f_t f;
      f = mk_arp(($urandom_range(0, 1) == 1) ? BCAST : LMAC,
                 ($urandom_range(0, 3) == 0) ? 16'h0002 : 16'h0001,
                 {16'($urandom), 32'($urandom)}, 32'($urandom), LIP);
      if ($urandom_range(0, 9) < 3) begin
         case ($urandom_range(0, 8))
            0: f.da  = {16'($urandom), 32'($urandom)};
            1: f.et  = 16'h0800;
            2: f.ht  = 16'h0006;
            3: f.pt  = 16'h86DD;
            4: f.hl  = 8'($urandom_range(0, 5));
            5: f.pl  = 8'd16;
            6: f.op  = 16'($urandom_range(0, 4));
            7: f.tpa = LIP + 32'($urandom_range(1, 9));
            default: f.tpa = 32'($urandom);
         endcase
      end
      return f;
   endfunction

   function automatic logic [63:0] rand_keep();
      logic [63:0] k;
      int          n;
      k = KALL;
      case ($urandom_range(0, 9))
         0: begin n = $urandom_range(30, 63); k = KALL >> (64 - n); end
         1: k[$urandom_range(0, 63)] = 1'b0;
         default: ;
      endcase
      return k;
   endfunction

   // Frame acceptance rule expressed on the generating fields, not on bus bits.
   function automatic logic addressed(input arp_f_t f, input logic [63:0] k);
      logic full;
      full = 1'b1;
      for (int i = 0; i < 42; i++) if (!k[i]) full = 1'b0;
      return full && f.et == 16'h0806 && f.ht == 16'h0001 && f.pt == 16'h0800 &&
             f.hl == 8'd6 && f.pl == 8'd4 && (f.da == LMAC || f.da == BCAST) && f.tpa == LIP;
   endfunction

   task automatic model_reset();
      m_rdy = 1'b0; m_sof = 1'b1; m_pend = 1'b0; m_peer_vld = 1'b0;
      m_src_mac = '0; m_src_ip = '0; m_peer_mac = '0; m_peer_ip = '0;
      m_req = 0; m_drop = 0;
   endtask

   task automatic model_step(input logic vld, input arp_f_t f, input logic [63:0] k,
                             input logic last, input logic done);
      logic was_pend;
      was_pend = m_pend;
      if (vld && m_rdy) begin
         if (m_sof && addressed(f, k)) begin
            if (f.op == 16'h0001) begin
               if (was_pend) m_drop = (m_drop < CMAX) ? m_drop + 1 : CMAX;
               else begin
                  m_pend = 1'b1; m_src_mac = f.sha; m_src_ip = f.spa;
                  m_req = (m_req < CMAX) ? m_req + 1 : CMAX;
               end
            end else if (f.op == 16'h0002) begin
               m_peer_mac = f.sha; m_peer_ip = f.spa; m_peer_vld = 1'b1;
            end
         end
         m_sof = last;
      end
      if (was_pend && done) m_pend = 1'b0;
      m_rdy = 1'b1;
   endtask

   task automatic check_all();
      chk_val("tready",     64'(tready),     64'(m_rdy));
      chk_val("ack",        64'(ack),        64'(m_pend));
      chk_val("src_mac",    64'(src_mac),    64'(m_src_mac));
      chk_val("src_ip",     64'(src_ip),     64'(m_src_ip));
      chk_val("peer_mac",   64'(peer_mac),   64'(m_peer_mac));
      chk_val("peer_ip",    64'(peer_ip),    64'(m_peer_ip));
      chk_val("peer_valid", 64'(peer_valid), 64'(m_peer_vld));
      chk_val("req_cnt",    64'(req_cnt),    64'(m_req));
      chk_val("drop_cnt",   64'(drop_cnt),   64'(m_drop));
   endtask

   task automatic cycle(input logic vld, input arp_f_t f, input logic [63:0] k,
                        input logic last, input logic done);
      tvalid = vld; tdata = mk_frame(f); tkeep = k; tlast = last; ack_done = done;
      @(posedge clk);
      #1;
      model_step(vld, f, k, last, done);
      check_all();
   endtask

   task automatic idle(input int n, input logic done);
      for (int i = 0; i < n; i++) cycle(1'b0, rand_frame(), KALL, 1'b0, done);
   endtask

   initial begin
      arp_f_t f, g;
      local_mac = LMAC; local_ip = LIP;
      rstn = 1'b0; tvalid = 1'b0; tlast = 1'b0; tdata = '0; tkeep = '0; ack_done = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_all();
      rstn = 1'b1;
      idle(2, 1'b0);

      // 1: broadcast request then done
      f = mk_arp(BCAST, 16'h0001, 48'h0011_2233_4455, 32'hC0A8_010A, LIP);
      cycle(1'b1, f, KALL, 1'b1, 1'b0);
      chk_val("t1_ack", 64'(ack), 64'd1);
      chk_val("t1_mac", 64'(src_mac), 64'h0011_2233_4455);
      chk_val("t1_ip",  64'(src_ip), 64'hC0A8_010A);
      chk_val("t1_cnt", 64'(req_cnt), 64'd1);
      idle(2, 1'b0);
      idle(1, 1'b1);
      chk_val("t1_ack_fall", 64'(ack), 64'd0);

      // 2: wrong TPA, wrong ethertype, short keep
      g = f; g.tpa = LIP + 32'd1;   cycle(1'b1, g, KALL, 1'b1, 1'b0);
      g = f; g.et = 16'h0800;       cycle(1'b1, g, KALL, 1'b1, 1'b0);
      cycle(1'b1, f, 64'h0000_00FF_FFFF_FFFF, 1'b1, 1'b0);
      chk_val("t2_ack", 64'(ack), 64'd0);
      chk_val("t2_req", 64'(req_cnt), 64'd1);
      chk_val("t2_drop", 64'(drop_cnt), 64'd0);

      // 3: second request while busy is dropped
      cycle(1'b1, f, KALL, 1'b1, 1'b0);
      idle(4, 1'b0);
      g = mk_arp(LMAC, 16'h0001, 48'h0099_8877_6655, 32'h0A01_0203, LIP);
      cycle(1'b1, g, KALL, 1'b1, 1'b0);
      chk_val("t3_drop", 64'(drop_cnt), 64'd1);
      chk_val("t3_mac", 64'(src_mac), 64'h0011_2233_4455);
      idle(1, 1'b1);

      // 4: ARP pattern inside a non-ARP frame is ignored
      g = f; g.et = 16'h0800;
      cycle(1'b1, g, KALL, 1'b0, 1'b0);
      cycle(1'b1, f, KALL, 1'b0, 1'b0);
      cycle(1'b1, f, KALL, 1'b1, 1'b0);
      chk_val("t4_ack_ignored", 64'(ack), 64'd0);
      cycle(1'b1, f, KALL, 1'b1, 1'b0);
      chk_val("t4_ack_accept", 64'(ack), 64'd1);
      idle(1, 1'b1);

      // 5: reply teaches the peer
      g = mk_arp(LMAC, 16'h0002, 48'hAABB_CCDD_EEFF, 32'h0A00_0001, LIP);
      cycle(1'b1, g, KALL, 1'b1, 1'b0);
      chk_val("t5_pvld", 64'(peer_valid), 64'd1);
      chk_val("t5_pmac", 64'(peer_mac), 64'hAABB_CCDD_EEFF);
      chk_val("t5_pip",  64'(peer_ip), 64'h0A00_0001);
      chk_val("t5_ack",  64'(ack), 64'd0);

      // 6: reset during a pending reply
      cycle(1'b1, f, KALL, 1'b1, 1'b0);
      rstn = 1'b0;
      #1;
      model_reset();
      check_all();
      chk_val("t6_ack", 64'(ack), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      check_all();
      rstn = 1'b1;
      cycle(1'b1, f, KALL, 1'b1, 1'b0);
      cycle(1'b1, f, KALL, 1'b1, 1'b0);
      chk_val("t6_after", 64'(ack), 64'd1);
      idle(1, 1'b1);

      // randomised traffic: multi-beat frames, gaps, stray done pulses
      for (int n = 0; n < 400; n++) begin
         int nb;
         nb = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 3) : 1;
         for (int bi = 0; bi < nb; bi++) begin
            cycle(1'b1, rand_frame(), rand_keep(), (bi == nb - 1),
                  ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 2) == 0)
               idle($urandom_range(1, 2), ($urandom_range(0, 3) == 0));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
